instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder.
- Holds the PC, issues word fetches to instruction memory over a req/gnt + rvalid interface, and buffers returned words in a small prefetch FIFO.
- Presents {instr, pc} to decode with a valid/ready handshake.
- Accepts a redirect from execute (branch/jump) that flushes in-flight and buffered instructions.

Parameters:
- DEPTH, 2, prefetch FIFO entries and maximum outstanding-plus-buffered fetches (power of 2, >= 2)
- RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- mem_req  out  1  fetch request valid
- mem_addr  out  32  fetch word address (bits[1:0] always 0)
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response data valid (in-order, >= 1 cycle after gnt)
- mem_rdata  in  32  response instruction word
- redirect_valid  in  1  control-flow change, one-cycle pulse
- redirect_pc  in  32  new fetch address
- instr_valid  out  1  instr/instr_pc valid to decode
- instr  out  32  instruction word
- instr_pc  out  32  address of instr
- instr_ready  in  1  decode accepts instr this cycle (low = stall)

Behaviour:
- Reset (rst=1 at a clock edge, also mid-operation):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop=0.
  - mem_req=0, instr_valid=0, mem_addr=RESET_PC.
  - Reset takes priority over every other input.
- Issue: mem_req=1 when (outstanding + fifo_count) < DEPTH and not halted.
  - mem_addr=fetch_pc.
  - On mem_req&&mem_gnt: fetch_pc+=4 (wraps modulo 2^32); outstanding+=1.
  - mem_addr must hold stable while mem_req=1 and gnt=0.
- Response: on mem_rvalid: outstanding-=1.
  - If drop>0: discard word, drop-=1.
  - Else push {mem_rdata, pc} into FIFO. pc comes from a resp_pc register that advances by 4 per accepted response.
- Output: instr_valid = FIFO non-empty; instr/instr_pc = FIFO head; pop on instr_valid&&instr_ready.
  - No combinational path from mem_rdata to instr; minimum latency is gnt -> rvalid -> instr_valid on the next cycle.
- Counter limits: push and pop in the same cycle keep the count unchanged. The FIFO never overflows, because the issue rule reserves a slot per outstanding request.
- Redirect (redirect_valid=1):
  - FIFO cleared; instr_valid=0 in the next cycle.
  - fetch_pc=redirect_pc and resp_pc=redirect_pc.
  - drop = outstanding after this cycle's gnt/rvalid updates, so every request issued before the redirect is discarded.
  - A request granted in the redirect cycle carries the old address and is counted into drop.
  - mem_req is forced 0 in the redirect cycle; the first new request is issued the cycle after.
  - A pop in the redirect cycle is still a valid handshake: decode consumed that instruction.
- Simultaneous events: redirect + rvalid → word dropped. redirect + gnt → counted in drop.
- No state machine beyond HALT (optional feature); otherwise always RUN.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN
- Enabled:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misaligned=1 and enters HALT: mem_req=0 and the FIFO is flushed.
  - Pending responses are still dropped.
  - HALT is left only by an aligned redirect, which clears fetch_misaligned, or by rst.
- Disabled:
  - No extra port.
  - redirect_pc[1:0] is ignored and forced to 0 in fetch_pc.

Test Plan:
- Reset, then mem_gnt=1 with rvalid one cycle after each gnt, instr_ready=1 → instr_pc sequence 0x0, 0x4, 0x8…; instr matches mem_rdata; first instr_valid on the 3rd cycle after rst falls.
- instr_ready=0 held, DEPTH=2 → exactly 2 grants, then mem_req=0; FIFO holds PCs 0x0 and 0x4. Raising ready drains them in order, then fetching resumes at 0x8.
- Two requests outstanding, redirect_pc=0x100 → both late responses dropped; next instr_valid carries instr_pc=0x100, and no 0x8/0xC instruction reaches decode.
- mem_gnt low for 3 cycles with mem_req high → mem_addr stable at the same value; fetch_pc advances only on the grant cycle.
- Redirect in the same cycle as rvalid and gnt → neither old word appears at decode; drop count correct, no FIFO overflow, no lost new-path instruction.
- (FETCH_MISALIGN_CHECK_EN) redirect_pc=0x102 → fetch_misaligned=1 and mem_req=0 until a redirect to 0x200, then fetch resumes at 0x200 with fetch_misaligned=0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/gnt/rvalid channel, the
// execute redirect, and the valid/ready handshake towards decode.
// master = fetch unit, slave = memory/decode/execute environment.
interface instr_fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc,
        input  mem_gnt, mem_rvalid, mem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc,
        output mem_gnt, mem_rvalid, mem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, word fetches over req/gnt + rvalid, a DEPTH
// entry prefetch FIFO feeding decode, and redirect-driven flushing.
// Optional macro FETCH_MISALIGN_CHECK_EN: a redirect to an unaligned PC
// raises fetch_misaligned and halts fetching until an aligned redirect.
module instr_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                fetch_misaligned
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } fetch_entry_t;

    fetch_entry_t   fifo_mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  fifo_cnt;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  drop;
    logic [31:0]    fetch_pc;
    logic [31:0]    resp_pc;
    logic           halted;

    logic           issue, drop_hit, push, pop;
    logic [CW-1:0]  outst_nxt;
    logic [31:0]    redir_pc_al;

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic {RUN, HALT} fetch_state_t;
    fetch_state_t state;
    logic         redir_bad;
    assign redir_bad = |bus.redirect_pc[1:0];
    assign halted    = (state == HALT);
`else
    assign halted    = 1'b0;
`endif

    // Low address bits never reach the PC; fetches are always word aligned.
    assign redir_pc_al = bus.redirect_pc & ~32'h3;

    // Issue only while every in-flight request still has a FIFO slot reserved;
    // the redirect cycle issues nothing so the new path starts cleanly next cycle.
    assign bus.mem_req  = !rst && !halted && !bus.redirect_valid &&
                          ((outstanding + fifo_cnt) < DEPTH_C);
    assign bus.mem_addr = fetch_pc;

    assign issue     = bus.mem_req && bus.mem_gnt;
    assign outst_nxt = outstanding + CW'(issue) - CW'(bus.mem_rvalid);
    assign drop_hit  = bus.mem_rvalid && (drop != '0);
    assign push      = bus.mem_rvalid && !drop_hit && !bus.redirect_valid;
    assign pop       = bus.instr_valid && bus.instr_ready;

    // Decode sees only registered FIFO state.
    assign bus.instr_valid = (fifo_cnt != '0);
    assign bus.instr       = fifo_mem[rd_ptr].word;
    assign bus.instr_pc    = fifo_mem[rd_ptr].pc;

    // FIFO storage; only the pointers/count need reset.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{word: bus.mem_rdata, pc: resp_pc};
    end

    // PC, outstanding/drop bookkeeping, FIFO pointers and halt state.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            state            <= RUN;
            fetch_misaligned <= 1'b0;
`endif
        end else begin
            outstanding <= outst_nxt;
            if (bus.redirect_valid) begin
                // Everything still in flight belongs to the old path.
                fetch_pc <= redir_pc_al;
                resp_pc  <= redir_pc_al;
                drop     <= outst_nxt;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
                if (redir_bad) begin
                    state            <= HALT;
                    fetch_misaligned <= 1'b1;
                end else begin
                    state            <= RUN;
                    fetch_misaligned <= 1'b0;
                end
`endif
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + 32'd4;
                if (drop_hit)
                    drop <= drop - 1'b1;
                if (push) begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                    2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (DEPTH=2, RESET_PC=0). A small memory
// model returns f(addr) one cycle after each grant unless responses are held.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus();
`ifdef FETCH_MISALIGN_CHECK_EN
    logic fetch_misaligned;
`endif

    instr_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    typedef struct {
        logic        r, g, rd, rv;
        logic [31:0] rp;
        logic        hold;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] pend[$];
    int          total = 0;
    int          bad   = 0;
    logic        s_req, s_vld;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] fmem(input logic [31:0] a);
        return a ^ 32'hC0DE_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, g, rd, rv, input logic [31:0] rp, input logic hold,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_vld, input logic [31:0] e_pc);
        vec_t v;
        v = '{r: r, g: g, rd: rd, rv: rv, rp: rp, hold: hold,
              e_req: e_req, e_addr: e_addr, e_vld: e_vld, e_pc: e_pc};
        vq.push_back(v);
    endtask

    // One clock: drive at negedge, sample 1ns later, record any grant.
    task automatic cyc(input logic r, g, rd, rv, input logic [31:0] rp, input logic hold);
        @(negedge clk);
        rst                = r;
        bus.mem_gnt        = g;
        bus.instr_ready    = rd;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        if (r) pend.delete();
        if (!r && !hold && pend.size() > 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = fmem(pend.pop_front());
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'h0;
        end
        #1;
        s_req   = bus.mem_req;
        s_addr  = bus.mem_addr;
        s_vld   = bus.instr_valid;
        s_pc    = bus.instr_pc;
        s_instr = bus.instr;
        if (s_vld === 1'b1) chk("instr_data", s_instr, fmem(s_pc));
        if (s_req === 1'b1 && g && !r) pend.push_back(s_addr);
    endtask

    initial begin
        rst = 1'b1;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;

        // streaming from reset
        add(1,1,1,0,0,0,      0,32'h000,0,0);
        add(0,1,1,0,0,0,      1,32'h000,0,0);
        add(0,1,1,0,0,0,      1,32'h004,0,0);
        add(0,1,1,0,0,0,      0,32'h008,1,32'h000);
        add(0,1,1,0,0,0,      1,32'h008,1,32'h004);
        add(0,1,1,0,0,0,      1,32'h00C,0,0);
        add(0,1,1,0,0,0,      0,32'h010,1,32'h008);
        add(0,1,1,0,0,0,      1,32'h010,1,32'h00C);
        // decode stalled: two grants fill the FIFO, then drain and resume
        add(1,1,0,0,0,0,      0,32'h014,0,0);
        add(0,1,0,0,0,0,      1,32'h000,0,0);
        add(0,1,0,0,0,0,      1,32'h004,0,0);
        add(0,1,0,0,0,0,      0,32'h008,1,32'h000);
        add(0,1,0,0,0,0,      0,32'h008,1,32'h000);
        add(0,1,0,0,0,0,      0,32'h008,1,32'h000);
        add(0,1,1,0,0,0,      0,32'h008,1,32'h000);
        add(0,1,1,0,0,0,      1,32'h008,1,32'h004);
        add(0,1,1,0,0,0,      1,32'h00C,0,0);
        add(0,1,1,0,0,0,      0,32'h010,1,32'h008);
        // two outstanding, redirect to 0x100, late responses dropped
        add(1,0,1,0,0,1,      0,32'h010,1,32'h00C);
        add(0,1,1,0,0,1,      1,32'h000,0,0);
        add(0,1,1,0,0,1,      1,32'h004,0,0);
        add(0,1,1,1,32'h100,1,0,32'h008,0,0);
        add(0,1,1,0,0,0,      0,32'h100,0,0);
        add(0,1,1,0,0,0,      1,32'h100,0,0);
        add(0,1,1,0,0,0,      1,32'h104,0,0);
        add(0,1,1,0,0,0,      0,32'h108,1,32'h100);
        add(0,1,1,0,0,0,      1,32'h108,1,32'h104);

        cyc(1,0,0,0,0,0);
        foreach (vq[i]) begin
            cyc(vq[i].r, vq[i].g, vq[i].rd, vq[i].rv, vq[i].rp, vq[i].hold);
            chk($sformatf("v%0d_req", i),  {31'b0, s_req}, {31'b0, vq[i].e_req});
            chk($sformatf("v%0d_addr", i), s_addr, vq[i].e_addr);
            chk($sformatf("v%0d_vld", i),  {31'b0, s_vld}, {31'b0, vq[i].e_vld});
            if (vq[i].e_vld) chk($sformatf("v%0d_pc", i), s_pc, vq[i].e_pc);
        end

        // grant withheld for 3 cycles: address holds, PC moves only on grant
        cyc(1,0,1,0,0,0);
        for (int k = 0; k < 3; k++) begin
            cyc(0,0,1,0,0,0);
            chk("stall_req",  {31'b0, s_req}, 32'd1);
            chk("stall_addr", s_addr, 32'h0);
        end
        cyc(0,1,1,0,0,0);
        chk("grant_addr", s_addr, 32'h0);
        cyc(0,0,1,0,0,0);
        chk("post_grant_addr", s_addr, 32'h4);

        // redirect coinciding with rvalid and gnt while two are outstanding
        cyc(1,0,1,0,0,0);
        cyc(0,1,1,0,0,1);
        cyc(0,1,1,0,0,1);
        cyc(0,1,1,1,32'h200,0);
        chk("redir_req", {31'b0, s_req}, 32'd0);
        cyc(0,1,1,0,0,0);
        chk("redir_new_req",  {31'b0, s_req}, 32'd1);
        chk("redir_new_addr", s_addr, 32'h200);
        chk("redir_no_old",   {31'b0, s_vld}, 32'd0);
        cyc(0,1,1,0,0,0);
        chk("redir_no_old2",  {31'b0, s_vld}, 32'd0);
        cyc(0,1,1,0,0,0);
        chk("redir_first_vld", {31'b0, s_vld}, 32'd1);
        chk("redir_first_pc",  s_pc, 32'h200);
        cyc(0,1,1,0,0,0);
        chk("redir_second_pc", s_pc, 32'h204);

`ifdef FETCH_MISALIGN_CHECK_EN
        // unaligned redirect halts fetch until an aligned redirect
        cyc(1,0,1,0,0,0);
        chk("mis_reset", {31'b0, fetch_misaligned}, 32'd0);
        cyc(0,0,1,1,32'h102,0);
        for (int k = 0; k < 3; k++) begin
            cyc(0,1,1,0,0,0);
            chk("mis_flag", {31'b0, fetch_misaligned}, 32'd1);
            chk("mis_req",  {31'b0, s_req}, 32'd0);
        end
        cyc(0,1,1,1,32'h200,0);
        cyc(0,1,1,0,0,0);
        chk("mis_clear", {31'b0, fetch_misaligned}, 32'd0);
        chk("mis_req2",  {31'b0, s_req}, 32'd1);
        chk("mis_addr",  s_addr, 32'h200);
        cyc(0,0,1,0,0,0);
        cyc(0,0,1,0,0,0);
        chk("mis_pc", s_pc, 32'h200);
`else
        // low redirect bits are ignored
        cyc(1,0,1,0,0,0);
        cyc(0,0,1,1,32'h103,0);
        cyc(0,0,1,0,0,0);
        chk("align_addr", s_addr, 32'h100);
        chk("align_req",  {31'b0, s_req}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
